time_counter_cap: RTL and testbench
===================================

# time_counter_cap

Parametrised timebase counter. It qualifies edges of an asynchronous reference strobe (e.g. the 12 MHz reference), divides them by a programmable prescaler and accumulates a TW-bit time count. It adds load, compare-alarm, overflow flag and NCAP timestamp-capture channels. It sits between the reference clock input and the timestamping/list logic, and supersedes the fixed 32-bit, rising-edge-only time counter.

## Interface
- TW, 32: time count width (≥8)
- DW, 16: prescaler width (≥2)
- NCAP, 2: number of capture channels (≥1)
- SYNC, 3: synchroniser depth for tick_in (≥2)

- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- tick_in  in  1  asynchronous reference strobe
- edge_sel  in  2  00 rising, 01 falling, 10 both edges, 11 counting disabled
- clr  in  1  synchronous clear of count, prescaler, ovf
- div  in  DW  prescaler: one count step per (div+1) qualified edges
- load  in  1  synchronous load of load_val into q
- load_val  in  TW  load value
- cmp_en  in  1  compare enable
- cmp_val  in  TW  compare value
- cap_trig  in  NCAP  capture strobes (clk domain, one per channel)
- cap_ack  in  NCAP  clear cap_vld per channel
- q  out  TW  time count
- tick_out  out  1  one-cycle pulse on every increment
- ovf  out  1  sticky wrap flag
- alarm  out  1  one-cycle compare pulse
- cap_q  out  NCAP*TW  captured counts, channel i at [i*TW +: TW]
- cap_vld  out  NCAP  sticky capture-valid
- cap_ovr  out  NCAP  sticky: capture overwritten while valid

## Operation
- Reset values: every register and output is 0. This includes the synchroniser, the prescaler and div_r.
- Edge qualification:
  - tick_in passes through a SYNC-stage chain plus one history register.
  - rise = s & ~h; fall = ~s & h.
  - The qualified edge is selected by edge_sel.
  - The history registers always run, so changing edge_sel never creates a spurious edge.
- div is registered into div_r every cycle.
- Prescaler pre (DW bits), on each qualified edge:
  - If pre ≥ div_r: pre ← 0 and an increment is issued.
  - Otherwise pre ← pre+1.
  - The ≥ test means lowering div below the current pre takes effect on the next edge and never waits for a 2^DW wrap.
  - div_r=0 gives one increment per qualified edge.
- Update priority per cycle: clr > load > increment.
  - clr: q, pre and ovf ← 0; alarm, tick_out ← 0.
  - load: q ← load_val, pre ← 0, ovf unchanged, no alarm, no tick_out. A qualified edge in the same cycle is dropped.
  - increment: q ← q+1 modulo 2^TW, tick_out ← 1.
- Wrap: incrementing from all-ones gives q=0 and sets ovf. ovf is cleared only by clr or rst.
- Alarm: alarm ← 1 on the cycle q is updated by increment to a value equal to cmp_val, with cmp_en=1. Otherwise alarm ← 0. Loads never raise alarm.
- Capture, channel i:
  - cap_trig[i] sets cap_q[i] ← q (the value before any same-cycle update) and cap_vld[i] ← 1.
  - If cap_vld[i] was already 1, cap_ovr[i] ← 1.
  - cap_ack[i] clears cap_vld[i] and cap_ovr[i].
  - When cap_trig[i] and cap_ack[i] are both set, trig wins: vld=1, ovr unchanged.
  - clr does not affect the capture registers.

## Timing
- tick_in transition to qualified-edge pulse: SYNC+1 clk cycles.
- Qualified edge to q/tick_out/alarm update: 1 clk. Total input-to-q latency is SYNC+2 cycles.
- A div change applies from the second clk after it is presented (div_r stage).
- tick_in high and low times must each be ≥ 2 clk periods. Narrower pulses may be missed; this is not detected.
- clr, load and cap_trig act on the next clk edge; results are visible one cycle later.
- rst may assert mid-count. All state returns to 0 asynchronously. After release the first edge can be qualified at the earliest SYNC+1 cycles later.
- cap_q, cap_vld and cap_ovr change only on clk edges.

## Test plan
- rst, then edge_sel=00, div=3, 20 rising edges of tick_in (period 8 clk) -> q=5 and 5 tick_out pulses. The first tick_out occurs SYNC+2 cycles after the 4th rising edge.
- edge_sel=10, div=0, 6 full tick_in periods -> q=12. Switching to 11 mid-stream -> q holds. Toggling edge_sel with tick_in static -> no increment.
- load_val=2^TW-2, div=0, 3 edges -> q sequence FFFFFFFE→FFFFFFFF→0→1, ovf=1 from the wrap cycle. A later load keeps ovf=1; clr -> ovf=0, q=0.
- cmp_en=1, cmp_val=7, count from 0 -> exactly one alarm pulse, coincident with q=7. Loading 7 -> no alarm. cmp_en=0 -> no alarm.
- At q=100, cap_trig[0] in the same cycle as an increment -> cap_q[0]=100, cap_vld[0]=1. A second trig -> cap_ovr[0]=1. trig+ack in the same cycle -> vld stays 1. ack alone -> vld=ovr=0. Channel 1 is unaffected throughout.
- div lowered from 10 to 2 while pre=7 -> increment on the next qualified edge, then every 3 edges. clr and load in the same cycle -> q=0.

Source files
------------

// File: rtl/time_counter_cap.sv
// Timebase counter: qualifies reference-strobe edges, prescales them and keeps a
// TW-bit count with load, compare alarm, sticky wrap flag and NCAP capture channels.
module time_counter_cap #(
  parameter int unsigned TW   = 32,
  parameter int unsigned DW   = 16,
  parameter int unsigned NCAP = 2,
  parameter int unsigned SYNC = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_in,
  input  logic [1:0]         edge_sel,
  input  logic               clr,
  input  logic [DW-1:0]      div,
  input  logic               load,
  input  logic [TW-1:0]      load_val,
  input  logic               cmp_en,
  input  logic [TW-1:0]      cmp_val,
  input  logic [NCAP-1:0]    cap_trig,
  input  logic [NCAP-1:0]    cap_ack,
  output logic [TW-1:0]      q,
  output logic               tick_out,
  output logic               ovf,
  output logic               alarm,
  output logic [NCAP*TW-1:0] cap_q,
  output logic [NCAP-1:0]    cap_vld,
  output logic [NCAP-1:0]    cap_ovr
);

  logic [SYNC-1:0] sync_r;
  logic            hist_r;
  logic            edge_r;
  logic [DW-1:0]   div_r;
  logic [DW-1:0]   pre_r;
  logic            sync_s;
  logic            rise_c;
  logic            fall_c;
  logic            edge_c;
  logic [TW-1:0]   q_inc;

  assign sync_s = sync_r[SYNC-1];
  assign rise_c = sync_s & ~hist_r;
  assign fall_c = ~sync_s & hist_r;
  assign q_inc  = q + TW'(1);

  // Edge select; the history keeps running so a select change never fakes an edge.
  always_comb begin
    edge_c = 1'b0;
    case (edge_sel)
      2'b00:   edge_c = rise_c;
      2'b01:   edge_c = fall_c;
      2'b10:   edge_c = rise_c | fall_c;
      default: edge_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= '0;
      hist_r <= 1'b0;
      edge_r <= 1'b0;
      div_r  <= '0;
    end else begin
      sync_r <= {sync_r[SYNC-2:0], tick_in};
      hist_r <= sync_s;
      edge_r <= edge_c;
      div_r  <= div;
    end
  end

  // Count update with priority clr > load > increment; >= test lets a lowered div act at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q        <= '0;
      pre_r    <= '0;
      ovf      <= 1'b0;
      tick_out <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      tick_out <= 1'b0;
      alarm    <= 1'b0;
      if (clr) begin
        q     <= '0;
        pre_r <= '0;
        ovf   <= 1'b0;
      end else if (load) begin
        q     <= load_val;
        pre_r <= '0;
      end else if (edge_r) begin
        if (pre_r >= div_r) begin
          pre_r    <= '0;
          q        <= q_inc;
          tick_out <= 1'b1;
          alarm    <= cmp_en && (q_inc == cmp_val);
          if (&q) ovf <= 1'b1;
        end else begin
          pre_r <= pre_r + DW'(1);
        end
      end
    end
  end

  // Capture channels sample q before any same-cycle update; trig beats ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q   <= '0;
      cap_vld <= '0;
      cap_ovr <= '0;
    end else begin
      for (int i = 0; i < NCAP; i++) begin
        if (cap_trig[i]) begin
          cap_q[i*TW +: TW] <= q;
          cap_vld[i]        <= 1'b1;
          if (cap_vld[i]) cap_ovr[i] <= 1'b1;
        end else if (cap_ack[i]) begin
          cap_vld[i] <= 1'b0;
          cap_ovr[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_time_counter_cap.sv
// Bench for time_counter_cap: directed scenarios plus random traffic, every cycle
// compared against a sample-history reference model.
module tb_time_counter_cap;
  localparam int unsigned TW   = 32;
  localparam int unsigned DW   = 16;
  localparam int unsigned NCAP = 2;
  localparam int unsigned SYNC = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               tick_in;
  logic [1:0]         edge_sel;
  logic               clr;
  logic [DW-1:0]      div;
  logic               load;
  logic [TW-1:0]      load_val;
  logic               cmp_en;
  logic [TW-1:0]      cmp_val;
  logic [NCAP-1:0]    cap_trig;
  logic [NCAP-1:0]    cap_ack;
  logic [TW-1:0]      q;
  logic               tick_out;
  logic               ovf;
  logic               alarm;
  logic [NCAP*TW-1:0] cap_q;
  logic [NCAP-1:0]    cap_vld;
  logic [NCAP-1:0]    cap_ovr;

  time_counter_cap #(.TW(TW), .DW(DW), .NCAP(NCAP), .SYNC(SYNC)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .edge_sel(edge_sel), .clr(clr),
    .div(div), .load(load), .load_val(load_val), .cmp_en(cmp_en), .cmp_val(cmp_val),
    .cap_trig(cap_trig), .cap_ack(cap_ack), .q(q), .tick_out(tick_out), .ovf(ovf),
    .alarm(alarm), .cap_q(cap_q), .cap_vld(cap_vld), .cap_ovr(cap_ovr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Reference model: th[j] is tick_in as sampled j clock edges ago. An increment
  // decision at this edge sees the edge between samples SYNC+2 and SYNC+1 ago,
  // with the edge_sel and div presented on the previous cycle.
  bit            th [SYNC+3];
  logic [1:0]    sel_prev = 2'b11;
  logic [DW-1:0] div_prev = '0;
  int unsigned   m_pre = 0;
  logic [TW-1:0] m_q = '0;
  logic          m_tick = 1'b0, m_ovf = 1'b0, m_alarm = 1'b0;
  logic [TW-1:0] m_cap [NCAP];
  logic [NCAP-1:0] m_vld = '0, m_ovr = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < SYNC + 3; j++) th[j] = 1'b0;
      sel_prev = 2'b11; div_prev = '0; m_pre = 0; m_q = '0;
      m_tick = 1'b0; m_ovf = 1'b0; m_alarm = 1'b0; m_vld = '0; m_ovr = '0;
      for (int i = 0; i < NCAP; i++) m_cap[i] = '0;
    end else begin
      bit s, h, e, inc;
      for (int j = SYNC + 2; j > 0; j--) th[j] = th[j-1];
      th[0] = tick_in;
      s = th[SYNC+1];
      h = th[SYNC+2];
      case (sel_prev)
        2'b00:   e = s && !h;
        2'b01:   e = !s && h;
        2'b10:   e = s != h;
        default: e = 1'b0;
      endcase
      inc = 1'b0;
      if (e && !clr && !load) begin
        if (m_pre >= int'(div_prev)) begin m_pre = 0; inc = 1'b1; end
        else m_pre = m_pre + 1;
      end
      for (int i = 0; i < NCAP; i++) begin
        if (cap_trig[i]) begin
          m_cap[i] = m_q;
          if (m_vld[i]) m_ovr[i] = 1'b1;
          m_vld[i] = 1'b1;
        end else if (cap_ack[i]) begin
          m_vld[i] = 1'b0; m_ovr[i] = 1'b0;
        end
      end
      m_tick = 1'b0; m_alarm = 1'b0;
      if (clr) begin
        m_q = '0; m_pre = 0; m_ovf = 1'b0;
      end else if (load) begin
        m_q = load_val; m_pre = 0;
      end else if (inc) begin
        if (m_q == {TW{1'b1}}) m_ovf = 1'b1;
        m_q = m_q + TW'(1);
        m_tick = 1'b1;
        m_alarm = cmp_en && (m_q == cmp_val);
      end
      sel_prev = edge_sel;
      div_prev = div;
    end
  end

  int tick_cnt = 0, alarm_cnt = 0, first_tick = -1;
  logic [TW-1:0] alarm_q = '0;

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("q", 64'(q), 64'(m_q));
      chk("tick_out", 64'(tick_out), 64'(m_tick));
      chk("ovf", 64'(ovf), 64'(m_ovf));
      chk("alarm", 64'(alarm), 64'(m_alarm));
      for (int i = 0; i < NCAP; i++) chk($sformatf("cap_q%0d", i), 64'(cap_q[i*TW +: TW]), 64'(m_cap[i]));
      chk("cap_vld", 64'(cap_vld), 64'(m_vld));
      chk("cap_ovr", 64'(cap_ovr), 64'(m_ovr));
      if (tick_out) begin
        tick_cnt++;
        if (first_tick < 0) first_tick = cyc;
      end
      if (alarm) begin alarm_cnt++; alarm_q = q; end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic settle();
    step(SYNC + 3);
  endtask

  task automatic pulse_clr();
    clr = 1'b1; step(1); clr = 1'b0;
  endtask

  task automatic do_load(input logic [TW-1:0] v);
    load_val = v; load = 1'b1; step(1); load = 1'b0;
  endtask

  task automatic periods(input int n, input int half);
    for (int i = 0; i < n; i++) begin
      tick_in = 1'b1; step(half);
      tick_in = 1'b0; step(half);
    end
  endtask

  int c4;
  int hold;

  initial begin
    rst = 1'b1; tick_in = 1'b0; edge_sel = 2'b00; clr = 1'b0; div = 16'd3;
    load = 1'b0; load_val = '0; cmp_en = 1'b0; cmp_val = '0; cap_trig = '0; cap_ack = '0;
    step(3);
    cmp_on = 1'b1;
    chk("reset_q", 64'(q), 64'd0);
    chk("reset_vld", 64'(cap_vld), 64'd0);
    rst = 1'b0;

    // Rising edges through div=3.
    tick_cnt = 0; first_tick = -1; c4 = 0;
    for (int i = 1; i <= 20; i++) begin
      tick_in = 1'b1;
      if (i == 4) c4 = cyc;
      step(4);
      tick_in = 1'b0; step(4);
    end
    settle();
    chk("div3_q", 64'(q), 64'd5);
    chk("div3_ticks", 64'(tick_cnt), 64'd5);
    chk("first_tick_latency", 64'(first_tick - c4), 64'(SYNC + 2));

    // Both edges, then disabled, then edge_sel toggling on a static strobe.
    div = '0; edge_sel = 2'b10; step(2); pulse_clr();
    periods(6, 4); settle();
    chk("both_q", 64'(q), 64'd12);
    edge_sel = 2'b11; periods(2, 4); settle();
    chk("disabled_q", 64'(q), 64'd12);
    for (int i = 0; i < 6; i++) begin edge_sel = 2'(i % 4); step(1); end
    settle();
    chk("sel_toggle_q", 64'(q), 64'd12);

    // Wrap and sticky ovf.
    edge_sel = 2'b10; do_load(32'hFFFF_FFFE);
    chk("load_q", 64'(q), 64'hFFFF_FFFE);
    tick_in = 1'b1; step(6);
    chk("wrap_q1", 64'(q), 64'hFFFF_FFFF);
    chk("wrap_ovf1", 64'(ovf), 64'd0);
    tick_in = 1'b0; step(6);
    chk("wrap_q2", 64'(q), 64'd0);
    chk("wrap_ovf2", 64'(ovf), 64'd1);
    tick_in = 1'b1; step(6);
    chk("wrap_q3", 64'(q), 64'd1);
    do_load(32'd5);
    chk("load_keeps_ovf", 64'(ovf), 64'd1);
    pulse_clr();
    chk("clr_ovf", 64'(ovf), 64'd0);
    chk("clr_q", 64'(q), 64'd0);

    // Compare alarm.
    cmp_en = 1'b1; cmp_val = 32'd7; alarm_cnt = 0;
    tick_in = 1'b0; settle(); pulse_clr();
    periods(5, 3); settle();
    chk("alarm_count", 64'(alarm_cnt), 64'd1);
    chk("alarm_at_q", 64'(alarm_q), 64'd7);
    do_load(32'd7); step(2);
    chk("load_no_alarm", 64'(alarm_cnt), 64'd1);
    cmp_en = 1'b0; pulse_clr();
    periods(5, 3); settle();
    chk("cmp_dis_alarm", 64'(alarm_cnt), 64'd1);
    chk("cmp_dis_q", 64'(q), 64'd10);

    // Capture coincident with an increment, overwrite, trig+ack, ack alone.
    do_load(32'd100);
    tick_in = 1'b1; step(SYNC + 1);
    cap_trig = 2'b01; step(1); cap_trig = '0;
    chk("cap0_q", 64'(cap_q[TW-1:0]), 64'd100);
    chk("cap0_vld", 64'(cap_vld[0]), 64'd1);
    chk("cap_inc_q", 64'(q), 64'd101);
    cap_trig = 2'b01; step(1); cap_trig = '0;
    chk("cap0_ovr", 64'(cap_ovr[0]), 64'd1);
    cap_trig = 2'b01; cap_ack = 2'b01; step(1); cap_trig = '0; cap_ack = '0;
    chk("trig_ack_vld", 64'(cap_vld[0]), 64'd1);
    cap_ack = 2'b01; step(1); cap_ack = '0;
    chk("ack_vld", 64'(cap_vld[0]), 64'd0);
    chk("ack_ovr", 64'(cap_ovr[0]), 64'd0);
    chk("ch1_vld", 64'(cap_vld[1]), 64'd0);
    chk("ch1_q", 64'(cap_q[2*TW-1:TW]), 64'd0);

    // Lowering div below the current prescale count.
    edge_sel = 2'b00; tick_in = 1'b0; div = 16'd10; settle(); pulse_clr();
    periods(7, 4); settle();
    chk("div10_q", 64'(q), 64'd0);
    div = 16'd2; step(2);
    periods(1, 4); settle();
    chk("div_lower_q1", 64'(q), 64'd1);
    periods(2, 4); settle();
    chk("div_lower_q1b", 64'(q), 64'd1);
    periods(1, 4); settle();
    chk("div_lower_q2", 64'(q), 64'd2);

    // clr beats load.
    clr = 1'b1; load = 1'b1; load_val = 32'd55; step(1); clr = 1'b0; load = 1'b0;
    chk("clr_over_load", 64'(q), 64'd0);

    // Reset mid-count.
    div = '0; edge_sel = 2'b10; do_load(32'd40);
    cap_trig = 2'b11; step(1); cap_trig = '0;
    tick_in = 1'b1; step(2);
    rst = 1'b1; #1;
    chk("mid_rst_q", 64'(q), 64'd0);
    chk("mid_rst_vld", 64'(cap_vld), 64'd0);
    step(2); rst = 1'b0; tick_in = 1'b0; step(2);

    // Random traffic against the model.
    hold = 0;
    for (int n = 0; n < 4000; n++) begin
      if (hold >= 2 && $urandom_range(0, 2) == 0) begin tick_in = ~tick_in; hold = 0; end
      else hold++;
      if ($urandom_range(0, 63) == 0) edge_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) div = DW'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) cmp_val = TW'($urandom_range(0, 15));
      cmp_en   = ($urandom_range(0, 3) != 0);
      clr      = ($urandom_range(0, 149) == 0);
      load     = ($urandom_range(0, 79) == 0);
      load_val = ($urandom_range(0, 1) == 0) ? TW'($urandom_range(0, 12))
                                             : 32'hFFFF_FFF0 + TW'($urandom_range(0, 15));
      for (int i = 0; i < NCAP; i++) begin
        cap_trig[i] = ($urandom_range(0, 9) == 0);
        cap_ack[i]  = ($urandom_range(0, 9) == 0);
      end
      rst = ($urandom_range(0, 1499) == 0);
      step(1);
    end
    rst = 1'b0; clr = 1'b0; load = 1'b0; cap_trig = '0; cap_ack = '0;
    step(SYNC + 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
